// File: rtl/leading_one_normalizer_pkg.sv
// Shared shift-mode codes and FSM state encoding for the leading-one normalizer.
package leading_one_normalizer_pkg;

    localparam logic [1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/leading_one_normalizer_if.sv
// Operand/result bundle between a requester (master) and the normalizer (slave).
// Handshake: start is a request sampled only while the block is idle; done pulses for one cycle and marks zero/norm_out/shamt valid until the next accepted start.
interface leading_one_normalizer_if #(
    parameter int SIZE  = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [SIZE-1:0]  din;
    logic             busy;
    logic             done;
    logic             zero;
    logic [SIZE-1:0]  norm_out;
    logic [CNT_W-1:0] shamt;

    modport master (
        output start, din,
        input  busy, done, zero, norm_out, shamt
    );

    modport slave (
        input  start, din,
        output busy, done, zero, norm_out, shamt
    );
endinterface

// File: rtl/leading_one_normalizer_ctrl.sv
// Control FSM: accepts a request, scans until the MSB is set or the operand is zero, then pulses done.
module leading_one_normalizer_ctrl
    import leading_one_normalizer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       msb_i,
    input  logic       is_zero_i,
    output logic [1:0] shift_mode_o,
    output logic       cnt_en_o,
    output logic       cnt_clr_o,
    output logic       zero_set_o,
    output logic       busy_o,
    output logic       done_o,
    output state_t     state_o
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        shift_mode_o = SHIFT_HOLD;
        cnt_en_o     = 1'b0;
        cnt_clr_o    = 1'b0;
        zero_set_o   = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_mode_o = SHIFT_LOAD;
                    cnt_clr_o    = 1'b1;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                busy_o = 1'b1;
                // Zero must be tested first: a zero operand never raises its MSB.
                if (is_zero_i) begin
                    zero_set_o = 1'b1;
                    state_d    = DONE;
                end else if (msb_i) begin
                    state_d = DONE;
                end else begin
                    shift_mode_o = SHIFT_LEFT;
                    cnt_en_o     = 1'b1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/leading_one_normalizer.sv
// Leading-one normalizer top: shift register, shift counter and zero flag around the control FSM.
module leading_one_normalizer
    import leading_one_normalizer_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int CNT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    leading_one_normalizer_if.slave   bus,
    output state_t                    dbg_state_o
);

    logic [SIZE-1:0]  data_q, data_d;
    logic [CNT_W-1:0] shamt_q, shamt_d;
    logic             zero_q, zero_d;
    logic [1:0]       shift_mode;
    logic             cnt_en, cnt_clr, zero_set;

    leading_one_normalizer_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start_i      (bus.start),
        .msb_i        (data_q[SIZE-1]),
        .is_zero_i    (data_q == '0),
        .shift_mode_o (shift_mode),
        .cnt_en_o     (cnt_en),
        .cnt_clr_o    (cnt_clr),
        .zero_set_o   (zero_set),
        .busy_o       (bus.busy),
        .done_o       (bus.done),
        .state_o      (dbg_state_o)
    );

    always_comb begin
        data_d = data_q;
        case (shift_mode)
            SHIFT_LEFT:  data_d = {data_q[SIZE-2:0], 1'b0};
            SHIFT_RIGHT: data_d = {1'b0, data_q[SIZE-1:1]};
            SHIFT_LOAD:  data_d = bus.din;
            default:     data_d = data_q;
        endcase
    end

    // The shift stops once the MSB is set, so shamt tops out at SIZE-1 without wrapping.
    always_comb begin
        shamt_d = shamt_q;
        if (cnt_clr)     shamt_d = '0;
        else if (cnt_en) shamt_d = shamt_q + CNT_W'(1);
    end

    always_comb begin
        zero_d = zero_q;
        if (cnt_clr)       zero_d = 1'b0;
        else if (zero_set) zero_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            shamt_q <= shamt_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.norm_out = data_q;
    assign bus.shamt    = shamt_q;
    assign bus.zero     = zero_q;

endmodule
